// File: rtl/mig_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mig_arb_pkg
// Description : Shared types and MIG command encodings for mig_app_arbiter.
// Revision    : 1.0
// ============================================================================
package mig_arb_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_ARB  = 3'd1,
    ST_WDF0 = 3'd2,
    ST_WDF1 = 3'd3,
    ST_CMD  = 3'd4
  } arb_state_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

endpackage
`default_nettype wire

// File: rtl/mig_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mig_tag_fifo
// Description : 1-bit-wide FIFO of read-burst owners, push+pop in one cycle.
// Revision    : 1.0
// ============================================================================
module mig_tag_fifo #(
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_push_data,
  input  logic                         i_pop,
  output logic                         o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(TAG_DEPTH):0]   o_count
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_mem [TAG_DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(TAG_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mig_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mig_app_arbiter
// Description : Round-robin two-client sequencer for the DDR3 MIG app port.
// Revision    : 1.0
// ============================================================================
module mig_app_arbiter
  import mig_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int APP_DW     = 256,
  parameter int APP_MW     = 32,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                        clk_sys,
  input  logic                        sys_rst,
  input  logic                        phy_init_done,
  input  logic                        req0_valid,
  input  logic                        req0_write,
  input  logic [ADDR_WIDTH-1:0]       req0_addr,
  input  logic [2*APP_DW-1:0]         req0_wdata,
  input  logic [2*APP_MW-1:0]         req0_wmask,
  output logic                        req0_ack,
  input  logic                        req1_valid,
  input  logic                        req1_write,
  input  logic [ADDR_WIDTH-1:0]       req1_addr,
  input  logic [2*APP_DW-1:0]         req1_wdata,
  input  logic [2*APP_MW-1:0]         req1_wmask,
  output logic                        req1_ack,
  output logic                        rsp0_valid,
  output logic                        rsp0_last,
  output logic                        rsp1_valid,
  output logic                        rsp1_last,
  output logic [APP_DW-1:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0]       app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  input  logic                        app_rdy,
  output logic [APP_DW-1:0]           app_wdf_data,
  output logic [APP_MW-1:0]           app_wdf_mask,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  input  logic                        app_wdf_rdy,
  input  logic [APP_DW-1:0]           app_rd_data,
  input  logic                        app_rd_data_valid,
  input  logic                        app_rd_data_end,
  output logic [$clog2(TAG_DEPTH):0]  rd_outstanding
);

  arb_state_t              r_state;
  arb_state_t              w_state_nx;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [2:0]              r_cmd;
  logic [2*APP_DW-1:0]     r_wdata;
  logic [2*APP_MW-1:0]     r_wmask;
  logic                    r_gnt;
  logic                    r_last;
  logic                    r_rd_err;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_head;
  logic                    w_elig0;
  logic                    w_elig1;
  logic                    w_pick1;
  logic                    w_grant;
  logic                    w_ack;
  logic                    w_rsp_ok;

  assign w_elig0 = req0_valid & (req0_write | ~w_full);
  assign w_elig1 = req1_valid & (req1_write | ~w_full);
  // r_last holds the most recent acked client; the other one wins a tie.
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);
  assign w_grant = w_elig0 | w_elig1;

  always_ff @(posedge clk_sys or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_INIT;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_ack        = 1'b0;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    app_wdf_data = r_wdata[APP_DW-1:0];
    app_wdf_mask = r_wmask[APP_MW-1:0];
    unique case (r_state)
      ST_INIT: if (phy_init_done) w_state_nx = ST_ARB;
      ST_ARB: begin
        if (w_grant)
          w_state_nx = (w_pick1 ? req1_write : req0_write) ? ST_WDF0 : ST_CMD;
      end
      ST_WDF0: begin
        app_wdf_wren = 1'b1;
        if (app_wdf_rdy) w_state_nx = ST_WDF1;
      end
      ST_WDF1: begin
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = r_wdata[2*APP_DW-1:APP_DW];
        app_wdf_mask = r_wmask[2*APP_MW-1:APP_MW];
        if (app_wdf_rdy) w_state_nx = ST_CMD;
      end
      ST_CMD: begin
        app_en = 1'b1;
        if (app_rdy) begin
          w_ack      = 1'b1;
          w_state_nx = ST_ARB;
        end
      end
      default: w_state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_sys or posedge sys_rst) begin
    if (sys_rst) begin
      r_addr   <= '0;
      r_cmd    <= CMD_WR;
      r_wdata  <= '0;
      r_wmask  <= '0;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_rd_err <= 1'b0;
    end else begin
      if (r_state == ST_ARB && w_grant) begin
        r_gnt   <= w_pick1;
        r_addr  <= w_pick1 ? req1_addr  : req0_addr;
        r_cmd   <= (w_pick1 ? req1_write : req0_write) ? CMD_WR : CMD_RD;
        r_wdata <= w_pick1 ? req1_wdata : req0_wdata;
        r_wmask <= w_pick1 ? req1_wmask : req0_wmask;
      end
      if (w_ack) r_last <= r_gnt;
      if (app_rd_data_valid && w_empty) r_rd_err <= 1'b1;
    end
  end

  assign app_addr = r_addr;
  assign app_cmd  = r_cmd;
  assign req0_ack = w_ack & ~r_gnt;
  assign req1_ack = w_ack &  r_gnt;

  mig_tag_fifo #(.TAG_DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk         (clk_sys),
    .rst         (sys_rst),
    .i_push      (w_ack && r_cmd == CMD_RD),
    .i_push_data (r_gnt),
    .i_pop       (app_rd_data_valid & app_rd_data_end),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (rd_outstanding)
  );

  // Beats arriving with no outstanding tag are dropped.
  assign w_rsp_ok   = app_rd_data_valid & ~w_empty;
  assign rsp0_valid = w_rsp_ok & ~w_head;
  assign rsp1_valid = w_rsp_ok &  w_head;
  assign rsp0_last  = rsp0_valid & app_rd_data_end;
  assign rsp1_last  = rsp1_valid & app_rd_data_end;
  assign rsp_data   = app_rd_data;

  a_no_orphan_rd: assert property (@(posedge clk_sys) disable iff (sys_rst) !r_rd_err);

endmodule
`default_nettype wire

// File: tb/tb_mig_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_app_arbiter
// Description : Directed/randomized self-checking bench for mig_app_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_mig_app_arbiter;
  import mig_arb_pkg::*;

  localparam int AW = 27;
  localparam int DW = 256;
  localparam int MW = 32;
  localparam int TD = 16;

  logic            clk_sys = 1'b0;
  logic            sys_rst = 1'b1;
  logic            phy_init_done = 1'b0;
  logic            req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0]   req0_addr = '0;
  logic [2*DW-1:0] req0_wdata = '0;
  logic [2*MW-1:0] req0_wmask = '0;
  logic            req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0]   req1_addr = '0;
  logic [2*DW-1:0] req1_wdata = '0;
  logic [2*MW-1:0] req1_wmask = '0;
  logic            app_rdy = 1'b1, app_wdf_rdy = 1'b1;
  logic [DW-1:0]   app_rd_data = '0;
  logic            app_rd_data_valid = 1'b0, app_rd_data_end = 1'b0;

  logic            req0_ack, req1_ack, rsp0_valid, rsp0_last, rsp1_valid, rsp1_last;
  logic [DW-1:0]   rsp_data, app_wdf_data;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en, app_wdf_wren, app_wdf_end;
  logic [MW-1:0]   app_wdf_mask;
  logic [4:0]      rd_outstanding;

  mig_app_arbiter #(.ADDR_WIDTH(AW), .APP_DW(DW), .APP_MW(MW), .TAG_DEPTH(TD)) dut (
    .clk_sys(clk_sys), .sys_rst(sys_rst), .phy_init_done(phy_init_done),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_ack(req1_ack),
    .rsp0_valid(rsp0_valid), .rsp0_last(rsp0_last), .rsp1_valid(rsp1_valid),
    .rsp1_last(rsp1_last), .rsp_data(rsp_data), .app_addr(app_addr),
    .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .rd_outstanding(rd_outstanding)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;
  int exp_tags[$];   // owners of acked reads, in issue order
  int last_gnt = 1;  // most recently acked client; 1 means client 0 wins the first tie

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom);
  endfunction

  task automatic wait_ack(input int client, input int budget, output int cyc);
    logic [1:0] seen;
    seen = 2'b00;
    cyc  = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (req0_ack || req1_ack) begin
        seen = {req1_ack, req0_ack};
        break;
      end
    end
    check($sformatf("ack_client%0d", client), seen, (client == 0) ? 2'b01 : 2'b10);
  endtask

  task automatic return_burst();
    logic [DW-1:0] d;
    int owner;
    owner = -1;
    if (exp_tags.size() > 0) owner = exp_tags.pop_front();
    for (int b = 0; b < 2; b++) begin
      d = rnd_beat();
      app_rd_data       = d;
      app_rd_data_valid = 1'b1;
      app_rd_data_end   = (b == 1);
      #1;
      check("rsp0_valid", rsp0_valid, owner == 0);
      check("rsp1_valid", rsp1_valid, owner == 1);
      check("rsp_last", rsp0_last | rsp1_last, b == 1);
      check("rsp_data", rsp_data, d);
      tick();
    end
    app_rd_data_valid = 1'b0;
    app_rd_data_end   = 1'b0;
  endtask

  initial begin
    int cyc;
    logic flag;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] beat_a, beat_b;
    logic [2*MW-1:0] m;

    // Reset state
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_ctrl", {app_en, app_wdf_wren, app_wdf_end, req0_ack, req1_ack}, 5'b0);
    check("rst_outstanding", rd_outstanding, 0);
    check("rst_addr_cmd", {app_addr, app_cmd}, 0);
    check("rst_wdf_data", app_wdf_data, 0);
    sys_rst = 1'b0;

    // No activity before calibration completes
    a0 = rnd_addr();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = a0;
    flag = 1'b0;
    repeat (50) begin
      tick();
      if (req0_ack || app_en) flag = 1'b1;
    end
    check("pre_init_quiet", flag, 1'b0);
    phy_init_done = 1'b1;
    wait_ack(0, 20, cyc);
    check("init_ack_latency_ge2", cyc >= 2, 1'b1);
    check("rd_cmd", app_cmd, CMD_RD);
    check("rd_addr", app_addr, a0);
    req0_valid = 1'b0;
    exp_tags.push_back(0); last_gnt = 0;
    tick();
    check("outstanding_1", rd_outstanding, 1);
    return_burst();
    check("outstanding_0", rd_outstanding, 0);

    // Write burst: two data beats precede the command
    beat_a = rnd_beat(); beat_b = rnd_beat();
    m = {$urandom, $urandom};
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = AW'(32'h100);
    req0_wdata = {beat_b, beat_a}; req0_wmask = m;
    tick();
    check("wdf0_ctrl", {app_wdf_wren, app_wdf_end, app_en}, 3'b100);
    check("wdf0_data", app_wdf_data, beat_a);
    check("wdf0_mask", app_wdf_mask, m[MW-1:0]);
    tick();
    check("wdf1_ctrl", {app_wdf_wren, app_wdf_end, app_en}, 3'b110);
    check("wdf1_data", app_wdf_data, beat_b);
    check("wdf1_mask", app_wdf_mask, m[2*MW-1:MW]);
    tick();
    check("wr_cmd_ctrl", {app_en, app_wdf_wren, req0_ack, req1_ack}, 4'b1010);
    check("wr_cmd", app_cmd, CMD_WR);
    check("wr_addr", app_addr, AW'(32'h100));
    req0_valid = 1'b0; req0_write = 1'b0;
    last_gnt = 0;
    tick();

    // Both clients stream reads: grants alternate
    a0 = rnd_addr(); a1 = rnd_addr();
    req0_valid = 1'b1; req0_addr = a0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = a1;
    for (int g = 0; g < 4; g++) begin
      int exp;
      exp = (last_gnt == 0) ? 1 : 0;
      wait_ack(exp, 20, cyc);
      check("rr_addr", app_addr, (exp == 1) ? a1 : a0);
      exp_tags.push_back(exp); last_gnt = exp;
      if (g == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end else if (exp == 1) begin
        a1 = rnd_addr(); req1_addr = a1;
      end else begin
        a0 = rnd_addr(); req0_addr = a0;
      end
    end
    tick();
    check("outstanding_4", rd_outstanding, 4);
    repeat (4) return_burst();
    check("outstanding_drained", rd_outstanding, 0);

    // Fill the tag FIFO; writes still pass, the next read waits for a pop
    req0_valid = 1'b1; req0_write = 1'b0;
    for (int i = 0; i < TD; i++) begin
      a0 = rnd_addr(); req0_addr = a0;
      wait_ack(0, 20, cyc);
      exp_tags.push_back(0); last_gnt = 0;
    end
    a0 = rnd_addr(); req0_addr = a0;
    tick();
    check("outstanding_full", rd_outstanding, TD);
    a1 = rnd_addr();
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = a1;
    req1_wdata = {rnd_beat(), rnd_beat()}; req1_wmask = '0;
    wait_ack(1, 20, cyc);
    check("full_write_latency", cyc, 3);
    check("full_write_addr", app_addr, a1);
    req1_valid = 1'b0; req1_write = 1'b0;
    last_gnt = 1;
    flag = 1'b0;
    repeat (10) begin
      tick();
      if (req0_ack) flag = 1'b1;
    end
    check("full_blocks_read", flag, 1'b0);
    return_burst();
    wait_ack(0, 20, cyc);
    check("read17_addr", app_addr, a0);
    req0_valid = 1'b0;
    exp_tags.push_back(0); last_gnt = 0;
    while (exp_tags.size() > 0) return_burst();
    check("outstanding_after_full", rd_outstanding, 0);

    // Command held while app_rdy is low
    app_rdy = 1'b0;
    a1 = rnd_addr();
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = a1;
    cyc = 0;
    while (cyc < 20 && !app_en) begin
      tick();
      cyc++;
    end
    check("stall_en", app_en, 1'b1);
    flag = 1'b0;
    repeat (10) begin
      tick();
      if (!app_en || app_addr !== a1 || app_cmd !== CMD_RD || req0_ack || req1_ack) flag = 1'b1;
    end
    check("stall_hold", flag, 1'b0);
    app_rdy = 1'b1;
    #1;
    check("stall_ack", {req1_ack, req0_ack}, 2'b10);
    req1_valid = 1'b0;
    exp_tags.push_back(1); last_gnt = 1;
    tick();
    return_burst();

    // Async reset in the middle of a write burst
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = rnd_addr();
    wait_ack(1, 20, cyc);
    req1_valid = 1'b0;
    tick();
    check("pre_rst_outstanding", rd_outstanding, 1);
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = rnd_addr();
    req0_wdata = {rnd_beat(), rnd_beat()}; req0_wmask = '1;
    tick();
    tick();
    check("in_wdf1", {app_wdf_wren, app_wdf_end}, 2'b11);
    sys_rst = 1'b1;
    #1;
    check("async_rst_ctrl", {app_en, app_wdf_wren, app_wdf_end, req0_ack, req1_ack}, 5'b0);
    check("async_rst_data", {app_wdf_data, app_wdf_mask}, 0);
    check("async_rst_outstanding", rd_outstanding, 0);
    exp_tags.delete();
    last_gnt = 1;
    sys_rst = 1'b0;
    cyc = 0;
    while (cyc < 10 && !app_wdf_wren) begin
      tick();
      cyc++;
    end
    check("post_rst_init_then_grant", cyc, 2);
    wait_ack(0, 20, cyc);
    req0_valid = 1'b0; req0_write = 1'b0;
    tick();
    check("final_outstanding", rd_outstanding, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
